// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter: round-robin arbiter driving load/clear/preset strobes of one shared register bank
module ff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  bank_en,
  output logic                  bank_clr,
  output logic                  bank_pre,
  output logic [WIDTH-1:0]      q
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RECOVER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, win;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d, q_q, q_d;
  logic en_q, en_d, bclr_q, bclr_d, pre_q, pre_d, busy_q, busy_d, any;
  logic [1:0] sel_op;
  // downward scan so the lowest offset from ptr wins
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % NREQ]) begin
        win = IW'((int'(ptr_q) + k) % NREQ);
        any = 1'b1;
      end
    sel_op = op[2*int'(win) +: 2];
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    data_d = data_q;
    q_d = q_q;
    gnt_d = '0;
    en_d = 1'b0;
    bclr_d = 1'b0;
    pre_d = 1'b0;
    busy_d = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        state_d = EXEC;
        win_d = win;
        data_d = wdata[int'(win)*WIDTH +: WIDTH];
        gnt_d = NREQ'(1) << win;
        en_d = sel_op == 2'b00;
        bclr_d = sel_op == 2'b01;
        pre_d = sel_op == 2'b10;
        busy_d = 1'b1;
      end
      EXEC: begin
        q_d = en_q ? data_q : bclr_q ? '0 : pre_q ? '1 : q_q;
        ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = (bclr_q || pre_q) ? RECOVER : IDLE;
        busy_d = bclr_q || pre_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      data_q <= '0;
      q_q <= INIT;
      gnt_q <= '0;
      en_q <= 1'b0;
      bclr_q <= 1'b0;
      pre_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      data_q <= data_d;
      q_q <= q_d;
      gnt_q <= gnt_d;
      en_q <= en_d;
      bclr_q <= bclr_d;
      pre_q <= pre_d;
      busy_q <= busy_d;
    end
  end
  assign gnt = gnt_q;
  assign busy = busy_q;
  assign bank_en = en_q;
  assign bank_clr = bclr_q;
  assign bank_pre = pre_q;
  assign q = q_q;
endmodule

// File: tb/tb_ff_bank_arbiter.sv
// tb_ff_bank_arbiter: vector table plus hand sequences for back-to-back, recovery and mid-exec reset
module tb_ff_bank_arbiter;
  localparam int N = 4, W = 8;
  logic clk = 1'b0, clr = 1'b1;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] op = '1;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0] gnt;
  logic busy, bank_en, bank_clr, bank_pre;
  logic [W-1:0] q;
  ff_bank_arbiter #(.NREQ(N), .WIDTH(W), .INIT(8'h00)) dut (
    .clk(clk), .clr(clr), .req(req), .op(op), .wdata(wdata), .gnt(gnt), .busy(busy),
    .bank_en(bank_en), .bank_clr(bank_clr), .bank_pre(bank_pre), .q(q)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [N-1:0] req; logic [2*N-1:0] op; logic [N*W-1:0] wd;
    logic [N-1:0] gnt; logic [2:0] str; logic [W-1:0] q; logic busy;
  } vec_t;
  typedef struct {logic [N-1:0] gnt; logic [2:0] str; logic [W-1:0] q; logic busy;} exp_t;
  exp_t sb[$];
  vec_t tbl[7];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask
  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gnt == '0 && lat < 20);
    if (gnt == '0) timeout("gnt_wait");
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (busy) timeout("idle_wait");
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    int lat;
    sb.push_back('{v.gnt, v.str, v.q, v.busy});
    req = v.req; op = v.op; wdata = v.wd;
    wait_gnt(lat);
    e = sb.pop_front();
    chk({nm, "_lat"}, lat, 1);
    chk({nm, "_gnt"}, gnt, e.gnt);
    chk({nm, "_str"}, {bank_en, bank_clr, bank_pre}, e.str);
    req = '0;
    @(negedge clk);
    chk({nm, "_q"}, q, e.q);
    chk({nm, "_busy"}, busy, e.busy);
    chk({nm, "_gnt_off"}, gnt, 0);
    chk({nm, "_str_off"}, {bank_en, bank_clr, bank_pre}, 0);
    wait_idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    exp_t e;
    int lat, ng, last;
    logic pend;
    logic [N-1:0] eg[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] es[5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b100};
    logic [W-1:0] eq[5] = '{8'h11, 8'h00, 8'hFF, 8'h44, 8'h11};
    int ed[4] = '{2, 3, 3, 2};
    repeat (2) @(negedge clk);
    clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_q", q, 8'h00);
      chk("rst_str", {bank_en, bank_clr, bank_pre}, 0);
    end
    tbl[0] = '{4'b0100, 8'hCF, 32'h00A5_0000, 4'b0100, 3'b100, 8'hA5, 1'b0};
    tbl[1] = '{4'b0010, 8'hFF, 32'h0000_0000, 4'b0010, 3'b000, 8'hA5, 1'b0};
    tbl[2] = '{4'b0101, 8'hDC, 32'h0000_0077, 4'b0100, 3'b010, 8'h00, 1'b1};
    tbl[3] = '{4'b1001, 8'hBC, 32'h0000_0055, 4'b1000, 3'b001, 8'hFF, 1'b1};
    tbl[4] = '{4'b1010, 8'h33, 32'h6600_5A00, 4'b0010, 3'b100, 8'h5A, 1'b0};
    tbl[5] = '{4'b1001, 8'h3C, 32'h3400_0012, 4'b1000, 3'b100, 8'h34, 1'b0};
    tbl[6] = '{4'b1111, 8'h00, 32'h4433_2211, 4'b0001, 3'b100, 8'h11, 1'b0};
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("v%0d", i));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 0; k < 5; k++) sb.push_back('{eg[k], es[k], eq[k], 1'b0});
    req = 4'hF; op = 8'h24; wdata = 32'h4400_0011;
    ng = 0; last = 0; pend = 1'b0;
    for (int c = 1; c <= 40 && ng < 5; c++) begin
      @(negedge clk);
      if (pend) begin
        chk("rr_q", q, e.q);
        pend = 1'b0;
      end
      if (gnt != '0) begin
        e = sb.pop_front();
        chk("rr_gnt", gnt, e.gnt);
        chk("rr_str", {bank_en, bank_clr, bank_pre}, e.str);
        if (ng > 0) chk("rr_gap", c - last, ed[ng-1]);
        last = c;
        ng++;
        pend = 1'b1;
        if (ng == 5) req = '0;
      end
    end
    if (ng < 5) timeout("rr_grants");
    @(negedge clk);
    chk("rr_q_last", q, 8'h11);
    wait_idle();
    req = 4'b0010; op = 8'hFB; wdata = '0;
    wait_gnt(lat);
    chk("rec_gnt", gnt, 4'b0010);
    chk("rec_pre", bank_pre, 1);
    req = '0;
    @(negedge clk);
    chk("rec_busy", busy, 1);
    chk("rec_gnt_off", gnt, 0);
    chk("rec_q", q, 8'hFF);
    req = 4'b0001; op = 8'hFC; wdata = 32'h0000_0099;
    @(negedge clk);
    chk("rec_idle_gnt", gnt, 0);
    chk("rec_idle_busy", busy, 0);
    @(negedge clk);
    chk("rec_next_gnt", gnt, 4'b0001);
    chk("rec_next_en", bank_en, 1);
    req = '0;
    @(negedge clk);
    chk("rec_next_q", q, 8'h99);
    wait_idle();
    req = 4'b1000; op = 8'h3F; wdata = 32'h3C00_0000;
    wait_gnt(lat);
    chk("abort_gnt", gnt, 4'b1000);
    clr = 1'b1; req = 4'b0011; op = 8'hF0; wdata = 32'h0000_BBAA;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_q", q, 8'h00);
    chk("abort_gnt_off", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_str", {bank_en, bank_clr, bank_pre}, 0);
    @(negedge clk);
    chk("abort_ptr_gnt", gnt, 4'b0001);
    req = '0;
    @(negedge clk);
    chk("abort_next_q", q, 8'hAA);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
